igr_epl_shim_aligner: RTL and testbench

//  Parametrised successor EPL rx shim. Serves NUM_PORTS logical ports sharing one EPL beat bus.

---
 rtl/igr_epl_shim_aligner.sv | 218 +++++++++++++++++++++
 tb/tb_igr_epl_shim_aligner.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/igr_epl_shim_aligner.sv
// igr_epl_shim_aligner: repacks per-port EPL beats into frame-aligned segments and
// round-robins the per-port segment FIFOs onto one valid/ready output stream.
module igr_epl_shim_aligner #(
  parameter int NUM_PORTS  = 4,
  parameter int WORD_W     = 72,
  parameter int SEG_WORDS  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int MD_W       = 32,
  localparam int PORT_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
  localparam int NW_W      = $clog2(SEG_WORDS) + 1,
  localparam int DW        = SEG_WORDS * WORD_W
) (
  input  logic                 cclk,
  input  logic                 rst_n,
  input  logic [PORT_W-1:0]    i_rx_port,
  input  logic [SEG_WORDS-1:0] i_rx_data_v,
  input  logic [DW-1:0]        i_rx_data,
  input  logic                 i_rx_sop,
  input  logic                 i_rx_eop,
  input  logic [MD_W-1:0]      i_rx_md,
  output logic                 o_seg_v,
  input  logic                 i_seg_rdy,
  output logic [DW-1:0]        o_seg_data,
  output logic [PORT_W-1:0]    o_seg_port,
  output logic                 o_seg_sop,
  output logic                 o_seg_eop,
  output logic                 o_seg_err,
  output logic [NW_W-1:0]      o_seg_nw,
  output logic [MD_W-1:0]      o_seg_md,
  output logic [NUM_PORTS-1:0] o_drop
);
  localparam int TW = NW_W + 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, FRAME, DROP, ABORT_PEND} st_t;
  typedef struct packed {
    logic [DW-1:0]   data;
    logic            sop;
    logic            eop;
    logic            err;
    logic [NW_W-1:0] nw;
    logic [MD_W-1:0] md;
  } seg_t;

  function automatic logic [AW-1:0] inc(input logic [AW-1:0] a);
    return (a == AW'(FIFO_DEPTH - 1)) ? '0 : a + 1'b1;
  endfunction

  logic                 s1_v, s1_sop, s1_eop;
  logic [PORT_W-1:0]    s1_port;
  logic [NW_W-1:0]      s1_n, n_in;
  logic [DW-1:0]        s1_data, mask;
  logic [MD_W-1:0]      s1_md;
  logic [NUM_PORTS-1:0] ne, drop_v, pop;
  seg_t                 head [NUM_PORTS];
  seg_t                 out_q;
  logic                 gnt_v, load;
  logic [PORT_W-1:0]    gnt, ptr;

  always_comb begin
    n_in = '0;
    mask = '0;
    for (int w = 0; w < SEG_WORDS; w++) begin
      n_in = n_in + NW_W'(i_rx_data_v[w]);
      mask[w*WORD_W +: WORD_W] = {WORD_W{i_rx_data_v[w]}};
    end
  end

  always_ff @(posedge cclk or negedge rst_n)
    if (!rst_n) begin
      s1_v    <= 1'b0;
      s1_sop  <= 1'b0;
      s1_eop  <= 1'b0;
      s1_port <= '0;
      s1_n    <= '0;
      s1_data <= '0;
      s1_md   <= '0;
    end else begin
      s1_v    <= |i_rx_data_v;
      s1_sop  <= i_rx_sop;
      s1_eop  <= i_rx_eop;
      s1_port <= i_rx_port;
      s1_n    <= n_in;
      s1_data <= i_rx_data & mask;
      s1_md   <= i_rx_md;
    end

  genvar p;
  for (p = 0; p < NUM_PORTS; p++) begin : g_port
    st_t             st, st_nx;
    logic [NW_W-1:0] rc, rc_nx, r_eff, rem;
    logic [DW-1:0]   rd, rd_nx;
    logic            first, first_nx, hit, fr, ap, ab, full, ok, drop;
    logic [MD_W-1:0] md;
    logic [TW-1:0]   tot;
    logic [2*DW-1:0] cat;
    logic [1:0]      fs, need, nwr;
    logic [CW:0]     free;
    seg_t            sa, sf0, sf1, w0, w1;
    seg_t            mem [FIFO_DEPTH];
    logic [AW-1:0]   wp, rp;
    logic [CW-1:0]   cnt;

    // ab: a closing err/abort segment precedes any data of this beat
    always_comb begin
      hit   = s1_v && s1_port == PORT_W'(p);
      ap    = st == ABORT_PEND || (st == DROP && hit && s1_sop);
      ab    = ap || (st == FRAME && hit && s1_sop);
      fr    = hit && (s1_sop || st == FRAME);
      r_eff = s1_sop ? '0 : rc;
      tot   = TW'(r_eff) + TW'(s1_n);
      cat   = {{DW{1'b0}}, (s1_sop ? '0 : rd)} | ({{DW{1'b0}}, s1_data} << (r_eff * WORD_W));
      full  = tot >= TW'(SEG_WORDS);
      rem   = NW_W'(full ? tot - TW'(SEG_WORDS) : tot);
      fs    = {1'b0, full} + {1'b0, s1_eop && rem != '0};
      need  = {1'b0, ab} + (fr ? fs : 2'd0);
      free  = (CW+1)'(FIFO_DEPTH) - (CW+1)'(cnt) - (CW+1)'(o_seg_v && o_seg_port == PORT_W'(p));
      ok    = free >= (CW+1)'(need);
      sa    = '{data: rd, sop: first, eop: 1'b1, err: 1'b1, nw: rc, md: md};
      sf0   = '{data: cat[DW-1:0], sop: s1_sop | first, eop: s1_eop && (!full || rem == '0),
                err: 1'b0, nw: full ? NW_W'(SEG_WORDS) : NW_W'(tot), md: s1_sop ? s1_md : md};
      sf1   = '{data: cat[2*DW-1:DW], sop: 1'b0, eop: 1'b1, err: 1'b0, nw: rem,
                md: s1_sop ? s1_md : md};
      w0    = ab ? sa : sf0;
      w1    = ab ? sf0 : sf1;
      nwr   = ok ? need : 2'd0;
      drop  = (hit && !s1_sop && (st == IDLE || st == ABORT_PEND)) || (fr && !ok);
      st_nx = st;
      rc_nx = rc;
      rd_nx = rd;
      first_nx = first;
      if (fr && !ok) begin
        st_nx    = (ap || s1_eop) ? ABORT_PEND : DROP;
        rc_nx    = '0;
        rd_nx    = '0;
        first_nx = 1'b0;
      end else if (fr) begin
        st_nx    = s1_eop ? IDLE : FRAME;
        rc_nx    = s1_eop ? '0 : rem;
        rd_nx    = s1_eop ? '0 : (full ? cat[2*DW-1:DW] : cat[DW-1:0]);
        first_nx = fs == 2'd0 && (s1_sop || first);
      end else if (ab && ok) begin
        st_nx    = IDLE;
        first_nx = 1'b0;
      end else if (st == DROP && hit && s1_eop) begin
        st_nx    = ABORT_PEND;
      end
    end

    always_ff @(posedge cclk or negedge rst_n)
      if (!rst_n) begin
        st    <= IDLE;
        rc    <= '0;
        rd    <= '0;
        first <= 1'b0;
        md    <= '0;
        wp    <= '0;
        rp    <= '0;
        cnt   <= '0;
      end else begin
        st    <= st_nx;
        rc    <= rc_nx;
        rd    <= rd_nx;
        first <= first_nx;
        if (fr && s1_sop) md <= s1_md;
        wp    <= (nwr == 2'd2) ? inc(inc(wp)) : (nwr == 2'd1) ? inc(wp) : wp;
        rp    <= pop[p] ? inc(rp) : rp;
        cnt   <= cnt + CW'(nwr) - CW'(pop[p]);
      end

    always_ff @(posedge cclk) begin
      if (nwr != 2'd0) mem[wp] <= w0;
      if (nwr == 2'd2) mem[inc(wp)] <= w1;
    end

    assign ne[p]     = cnt != '0;
    assign drop_v[p] = drop;
    assign head[p]   = mem[rp];
  end

  always_comb begin
    gnt_v = 1'b0;
    gnt   = '0;
    for (int k = 0; k < NUM_PORTS; k++)
      if (!gnt_v && ne[(int'(ptr) + k) % NUM_PORTS]) begin
        gnt_v = 1'b1;
        gnt   = PORT_W'((int'(ptr) + k) % NUM_PORTS);
      end
  end

  assign load = !o_seg_v || i_seg_rdy;
  assign pop  = (load && gnt_v) ? (NUM_PORTS'(1) << gnt) : '0;

  always_ff @(posedge cclk or negedge rst_n)
    if (!rst_n) begin
      o_seg_v    <= 1'b0;
      o_seg_port <= '0;
      out_q      <= '0;
      o_drop     <= '0;
      ptr        <= '0;
    end else begin
      o_drop <= drop_v;
      if (load) begin
        o_seg_v    <= gnt_v;
        o_seg_port <= gnt_v ? gnt : '0;
        out_q      <= gnt_v ? head[gnt] : '0;
        if (gnt_v) ptr <= (gnt == PORT_W'(NUM_PORTS - 1)) ? '0 : gnt + 1'b1;
      end
    end

  assign o_seg_data = out_q.data;
  assign o_seg_sop  = out_q.sop;
  assign o_seg_eop  = out_q.eop;
  assign o_seg_err  = out_q.err;
  assign o_seg_nw   = out_q.nw;
  assign o_seg_md   = out_q.md;
endmodule

// File: tb/tb_igr_epl_shim_aligner.sv
// tb_igr_epl_shim_aligner: directed self-checking bench for the EPL rx shim aligner.
module tb_igr_epl_shim_aligner;
  localparam int DW = 576;

  logic          cclk = 1'b0;
  logic          rst_n;
  logic [1:0]    i_rx_port;
  logic [7:0]    i_rx_data_v;
  logic [DW-1:0] i_rx_data;
  logic          i_rx_sop, i_rx_eop;
  logic [31:0]   i_rx_md;
  logic          o_seg_v, i_seg_rdy;
  logic [DW-1:0] o_seg_data;
  logic [1:0]    o_seg_port;
  logic          o_seg_sop, o_seg_eop, o_seg_err;
  logic [3:0]    o_seg_nw;
  logic [31:0]   o_seg_md;
  logic [3:0]    o_drop;

  int n_cmp = 0;
  int n_bad = 0;
  int drop_cnt [4];

  igr_epl_shim_aligner dut (
    .cclk(cclk), .rst_n(rst_n), .i_rx_port(i_rx_port), .i_rx_data_v(i_rx_data_v),
    .i_rx_data(i_rx_data), .i_rx_sop(i_rx_sop), .i_rx_eop(i_rx_eop), .i_rx_md(i_rx_md),
    .o_seg_v(o_seg_v), .i_seg_rdy(i_seg_rdy), .o_seg_data(o_seg_data), .o_seg_port(o_seg_port),
    .o_seg_sop(o_seg_sop), .o_seg_eop(o_seg_eop), .o_seg_err(o_seg_err), .o_seg_nw(o_seg_nw),
    .o_seg_md(o_seg_md), .o_drop(o_drop)
  );

  always #5 cclk = ~cclk;

  initial for (int i = 0; i < 4; i++) drop_cnt[i] = 0;

  always @(negedge cclk)
    for (int i = 0; i < 4; i++) drop_cnt[i] = drop_cnt[i] + int'(o_drop[i]);

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge cclk);
    #1;
  endtask

  function automatic logic [DW-1:0] mk(input int base, input int nw);
    logic [DW-1:0] d = '0;
    for (int i = 0; i < 8; i++) d[i*72 +: 72] = (i < nw) ? 72'(base + i) : 72'h0;
    return d;
  endfunction

  task automatic send(input int port, input int n, input bit sop, input bit eop,
                      input logic [31:0] md, input int base);
    i_rx_port   = 2'(port);
    i_rx_data_v = 8'((1 << n) - 1);
    for (int i = 0; i < 8; i++) i_rx_data[i*72 +: 72] = (i < n) ? 72'(base + i) : 72'hDEAD;
    i_rx_sop = sop;
    i_rx_eop = eop;
    i_rx_md  = md;
    tick;
  endtask

  task automatic quiet;
    i_rx_data_v = '0;
    i_rx_sop    = 1'b0;
    i_rx_eop    = 1'b0;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    repeat (2) tick;
    rst_n = 1'b1;
    tick;
  endtask

  task automatic expect_seg(input string tag, input int port, input bit sop, input bit eop,
                            input bit err, input int nw, input int base, input logic [31:0] md);
    int t = 0;
    while (!(o_seg_v && i_seg_rdy) && t < 100) begin
      tick;
      t++;
    end
    chk({tag, "_v"}, DW'(o_seg_v && i_seg_rdy), DW'(1));
    chk({tag, "_port"}, DW'(o_seg_port), DW'(port));
    chk({tag, "_flags"}, DW'({o_seg_sop, o_seg_eop, o_seg_err}), DW'({sop, eop, err}));
    chk({tag, "_nw"}, DW'(o_seg_nw), DW'(nw));
    chk({tag, "_md"}, DW'(o_seg_md), DW'(md));
    chk({tag, "_data"}, o_seg_data, mk(base, nw));
    tick;
  endtask

  initial begin
    int d;
    rst_n = 1'b0;
    i_seg_rdy = 1'b1;
    i_rx_port = '0;
    i_rx_data = '0;
    i_rx_md = '0;
    quiet;
    repeat (3) tick;
    chk("rst_v", DW'(o_seg_v), DW'(0));
    chk("rst_drop", DW'(o_drop), DW'(0));
    chk("rst_data", o_seg_data, '0);
    chk("rst_misc", DW'({o_seg_port, o_seg_sop, o_seg_eop, o_seg_err, o_seg_nw, o_seg_md}), DW'(0));
    rst_n = 1'b1;
    tick;

    send(2, 8, 1, 0, 32'hA1, 'h100);
    quiet;
    tick;
    chk("t1_early", DW'(o_seg_v), DW'(0));
    tick;
    chk("t1_lat", DW'(o_seg_v), DW'(1));
    expect_seg("t1_s0", 2, 1, 0, 0, 8, 'h100, 32'hA1);
    send(2, 3, 0, 1, 32'hFF, 'h108);
    quiet;
    expect_seg("t1_s1", 2, 0, 1, 0, 3, 'h108, 32'hA1);
    d = drop_cnt[2];
    send(2, 4, 0, 1, 32'h0, 'h180);
    quiet;
    repeat (4) tick;
    chk("orphan_drop", DW'(drop_cnt[2] - d), DW'(1));
    chk("orphan_noseg", DW'(o_seg_v), DW'(0));

    send(0, 7, 1, 0, 32'hB2, 'h200);
    send(0, 8, 0, 1, 32'h0, 'h207);
    quiet;
    expect_seg("t2_s0", 0, 1, 0, 0, 8, 'h200, 32'hB2);
    expect_seg("t2_s1", 0, 0, 1, 0, 7, 'h208, 32'hB2);

    chk("t3_drop_before", DW'(drop_cnt[1]), DW'(0));
    i_seg_rdy = 1'b0;
    send(1, 8, 1, 0, 32'hC3, 'h300);
    for (int b = 1; b < 5; b++) send(1, 8, 0, b == 4, 32'h0, 'h300 + 8 * b);
    quiet;
    repeat (6) tick;
    chk("t3_drop", DW'(drop_cnt[1]), DW'(1));
    chk("t3_hold", DW'(o_seg_v), DW'(1));
    i_seg_rdy = 1'b1;
    for (int b = 0; b < 4; b++) expect_seg("t3_seg", 1, b == 0, 0, 0, 8, 'h300 + 8 * b, 32'hC3);
    expect_seg("t3_abort", 1, 0, 1, 1, 0, 0, 32'hC3);
    repeat (5) tick;
    chk("t3_empty", DW'(o_seg_v), DW'(0));

    send(3, 3, 1, 0, 32'hD4, 'h400);
    send(3, 5, 1, 1, 32'hE5, 'h500);
    quiet;
    expect_seg("t4_trunc", 3, 1, 1, 1, 3, 'h400, 32'hD4);
    expect_seg("t4_new", 3, 1, 1, 0, 5, 'h500, 32'hE5);

    do_reset;
    i_seg_rdy = 1'b0;
    for (int q = 0; q < 4; q++) begin
      send(q, 8, 1, 0, 32'hA500 + q, 'h600 + q * 'h20);
      send(q, 8, 0, 1, 32'h0, 'h608 + q * 'h20);
    end
    quiet;
    repeat (6) tick;
    for (int k = 0; k < 8; k++) begin
      i_seg_rdy = 1'b0;
      tick;
      chk("t5_hold_port", DW'({o_seg_v, o_seg_port}), DW'({1'b1, 2'(k % 4)}));
      chk("t5_hold_data", o_seg_data, mk('h600 + (k % 4) * 'h20 + (k / 4) * 8, 8));
      i_seg_rdy = 1'b1;
      expect_seg("t5_rr", k % 4, k < 4, k >= 4, 0, 8, 'h600 + (k % 4) * 'h20 + (k / 4) * 8,
                 32'hA500 + k % 4);
    end

    i_seg_rdy = 1'b0;
    send(0, 8, 1, 0, 32'hF6, 'h700);
    quiet;
    repeat (2) tick;
    chk("t6_pre", DW'(o_seg_v), DW'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_v", DW'(o_seg_v), DW'(0));
    chk("t6_rst_data", o_seg_data, '0);
    chk("t6_rst_misc", DW'({o_seg_port, o_seg_sop, o_seg_eop, o_seg_err, o_seg_nw, o_seg_md}), DW'(0));
    tick;
    rst_n = 1'b1;
    tick;
    i_seg_rdy = 1'b1;
    send(0, 4, 1, 1, 32'h77, 'h800);
    quiet;
    expect_seg("t6_clean", 0, 1, 1, 0, 4, 'h800, 32'h77);
    repeat (5) tick;
    chk("t6_empty", DW'(o_seg_v), DW'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
endmodule
